// File: rtl/riscv_ex_sched_if.sv
// ID/EX/WB scheduler bundle: decode operands, issue handshake, writeback
// and flush going into the scheduler; issue_ok and status coming back out.
// slave modport = scheduler side, master modport = pipeline/driver side.
// Ports: dec_* (decoded instruction), id_ex_rdy/id_ex_ack (issue
// handshake), wb_* (retire), flush, issue_ok, sb_busy, inflight,
// stall_cnt, sb_err.
interface riscv_ex_sched_if #(
  parameter int INF_W = 4
);
  logic             dec_vld;
  logic [4:0]       dec_rs1;
  logic             dec_rs1_en;
  logic [4:0]       dec_rs2;
  logic             dec_rs2_en;
  logic [4:0]       dec_rd;
  logic             dec_rd_we;
  logic             id_ex_rdy;
  logic             id_ex_ack;
  logic             wb_vld;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic             flush;
  logic             issue_ok;
  logic             sb_busy;
  logic [INF_W-1:0] inflight;
  logic [15:0]      stall_cnt;
  logic             sb_err;

  modport slave (
    input  dec_vld, dec_rs1, dec_rs1_en, dec_rs2, dec_rs2_en, dec_rd, dec_rd_we,
    input  id_ex_rdy, id_ex_ack, wb_vld, wb_we, wb_rd, flush,
    output issue_ok, sb_busy, inflight, stall_cnt, sb_err
  );

  modport master (
    output dec_vld, dec_rs1, dec_rs1_en, dec_rs2, dec_rs2_en, dec_rd, dec_rd_we,
    output id_ex_rdy, id_ex_ack, wb_vld, wb_we, wb_rd, flush,
    input  issue_ok, sb_busy, inflight, stall_cnt, sb_err
  );
endinterface

// File: rtl/riscv_ex_sched.sv
// Purpose: ID->EX issue scheduler with per-register pending-write scoreboard.
// Latency: issue_ok is combinational (0 cycles); state updates on next edge.
// Backpressure: issue_ok low on RAW, saturated WAW, full depth or flush.
// Ports: clk, rst (sync, active-high), bus (riscv_ex_sched_if.slave).
// Optional build macro RISCV_SB_WB_BYPASS_EN: a source whose last pending
// write retires this cycle is not treated as a hazard (regfile write-through).
module riscv_ex_sched #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int INF_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  riscv_ex_sched_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);
  localparam logic [INF_W-1:0] INF_ONE = INF_W'(1);

  // Entry 0 exists only so x0 can be indexed; it is held at zero.
  logic [CNT_W-1:0] r_cnt [32];
  logic [INF_W-1:0] r_inflight;
  logic [15:0]      r_stall_cnt;
  logic             r_sb_err;
  logic             r_sb_busy;

  logic [CNT_W-1:0] w_cnt_nxt [32];
  logic [INF_W-1:0] w_inflight_nxt;
  logic             w_busy_nxt;
  logic             w_cnt_err;
  logic             w_inf_err;
  logic             w_byp1;
  logic             w_byp2;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_waw;
  logic             w_full;
  logic             w_issue_ok;
  logic             w_fire;
  logic             w_fire_reg;
  logic             w_ret_reg;
  logic             w_stall;

`ifdef RISCV_SB_WB_BYPASS_EN
  // Last outstanding write to the source lands this cycle; the register file
  // forwards it, so the reader can leave ID in the same cycle.
  assign w_byp1 = bus.wb_vld & bus.wb_we & (bus.wb_rd == bus.dec_rs1) &
                  (r_cnt[bus.dec_rs1] == CNT_ONE);
  assign w_byp2 = bus.wb_vld & bus.wb_we & (bus.wb_rd == bus.dec_rs2) &
                  (r_cnt[bus.dec_rs2] == CNT_ONE);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_raw1 = bus.dec_rs1_en & (bus.dec_rs1 != 5'd0) &
                  (r_cnt[bus.dec_rs1] != '0) & ~w_byp1;
  assign w_raw2 = bus.dec_rs2_en & (bus.dec_rs2 != 5'd0) &
                  (r_cnt[bus.dec_rs2] != '0) & ~w_byp2;
  assign w_waw  = bus.dec_rd_we & (bus.dec_rd != 5'd0) &
                  (r_cnt[bus.dec_rd] == CNT_MAX);
  // A retirement in the same cycle frees a slot for the incoming issue.
  assign w_full = (r_inflight == INF_MAX) & ~bus.wb_vld;

  assign w_issue_ok = bus.dec_vld & ~w_raw1 & ~w_raw2 & ~w_waw & ~w_full & ~bus.flush;

  assign w_fire     = bus.id_ex_rdy & bus.id_ex_ack;
  assign w_fire_reg = w_fire & bus.dec_rd_we & (bus.dec_rd != 5'd0);
  assign w_ret_reg  = bus.wb_vld & bus.wb_we & (bus.wb_rd != 5'd0);
  assign w_stall    = bus.dec_vld & ~w_issue_ok & ~bus.flush;

  // Per-register next value. Out-of-range results hold the old value and
  // raise an error instead of wrapping. Flush zeroes everything.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_cnt_err  = 1'b0;
    w_busy_nxt = 1'b0;
    w_cnt_nxt[0] = '0;
    for (int i = 1; i < 32; i++) begin
      if (bus.flush) begin
        w_cnt_nxt[i] = '0;
      end else if (w_fire_reg && (bus.dec_rd == 5'(i)) &&
                   !(w_ret_reg && (bus.wb_rd == 5'(i)))) begin
        if (r_cnt[i] == CNT_MAX) w_cnt_err = 1'b1;
        else                     w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      end else if (w_ret_reg && (bus.wb_rd == 5'(i))) begin
        // Retire alone decrements; retire+fire on the same register nets to
        // zero, but retiring a non-pending register is still a protocol error.
        if (r_cnt[i] == '0)                            w_cnt_err = 1'b1;
        else if (!(w_fire_reg && bus.dec_rd == 5'(i))) w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
      end
      w_busy_nxt = w_busy_nxt | (w_cnt_nxt[i] != '0);
    end
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    w_inf_err      = 1'b0;
    if (bus.flush) begin
      w_inflight_nxt = '0;
    end else if (w_fire && !bus.wb_vld) begin
      if (r_inflight == INF_MAX) w_inf_err = 1'b1;
      else                       w_inflight_nxt = r_inflight + INF_ONE;
    end else if (bus.wb_vld) begin
      if (r_inflight == '0) w_inf_err = 1'b1;
      else if (!w_fire)     w_inflight_nxt = r_inflight - INF_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
      r_inflight  <= '0;
      r_stall_cnt <= '0;
      r_sb_err    <= 1'b0;
      r_sb_busy   <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_inflight <= w_inflight_nxt;
      r_sb_busy  <= w_busy_nxt;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      // Fire and retire are void during flush, so they cannot flag errors.
      if (!bus.flush && ((w_fire && !w_issue_ok) || w_cnt_err || w_inf_err))
        r_sb_err <= 1'b1;
    end
  end

  assign bus.issue_ok  = w_issue_ok;
  assign bus.sb_busy   = r_sb_busy;
  assign bus.inflight  = r_inflight;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.sb_err    = r_sb_err;

endmodule

// File: tb/tb_riscv_ex_sched.sv
module tb_riscv_ex_sched;
  localparam int MAXI = 4;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_ex_sched_if #(.INF_W(4)) bus ();

  riscv_ex_sched #(.CNT_W(2), .MAX_INFLIGHT(MAXI), .INF_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: outstanding writes per register and in-flight count as
  // plain integers, updated from the rules with whole-number arithmetic.
  int m_pend [32];
  int m_infl;
  int m_stall;
  bit m_err;

  int n_vec = 0;
  int n_bad = 0;

`ifdef RISCV_SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit src_blocked(input bit en, input logic [4:0] rs);
    if (!en || rs == 0 || m_pend[rs] == 0) return 1'b0;
    if (BYP && bus.wb_vld && bus.wb_we && bus.wb_rd == rs && m_pend[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_ok();
    bit blk;
    blk = src_blocked(bus.dec_rs1_en, bus.dec_rs1) || src_blocked(bus.dec_rs2_en, bus.dec_rs2);
    if (bus.dec_rd_we && bus.dec_rd != 0 && m_pend[bus.dec_rd] == CMAX) blk = 1'b1;
    if (m_infl == MAXI && !bus.wb_vld) blk = 1'b1;
    return bus.dec_vld && !blk && !bus.flush;
  endfunction

  function automatic bit model_busy();
    for (int r = 1; r < 32; r++) if (m_pend[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_dec(input bit v, input logic [4:0] rs1, input bit e1,
                         input logic [4:0] rs2, input bit e2, input logic [4:0] rd, input bit we);
    bus.dec_vld = v; bus.dec_rs1 = rs1; bus.dec_rs1_en = e1;
    bus.dec_rs2 = rs2; bus.dec_rs2_en = e2; bus.dec_rd = rd; bus.dec_rd_we = we;
  endtask

  task automatic set_wb(input bit v, input bit we, input logic [4:0] rd);
    bus.wb_vld = v; bus.wb_we = we; bus.wb_rd = rd;
  endtask

  task automatic set_fire(input bit rdy, input bit ack);
    bus.id_ex_rdy = rdy; bus.id_ex_ack = ack;
  endtask

  // One cycle: inputs already driven after a falling edge. Check issue_ok
  // (and optionally a planned constant), clock, update model, check state.
  task automatic step(input int want_ok);
    bit ok, fire;
    int d [32];
    int ni, nv;
    #1;
    ok = model_ok();
    chk("issue_ok", 32'(bus.issue_ok), 32'(ok));
    if (want_ok >= 0) chk("issue_ok_plan", 32'(bus.issue_ok), 32'(want_ok));
    fire = bus.id_ex_rdy && bus.id_ex_ack;
    if (bus.dec_vld && !ok && !bus.flush && m_stall < 65535) m_stall++;
    if (bus.flush) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
      m_infl = 0;
    end else begin
      if (fire && !ok) m_err = 1'b1;
      if (bus.wb_vld && m_infl == 0) m_err = 1'b1;
      ni = m_infl + int'(fire) - int'(bus.wb_vld);
      if (ni < 0 || ni > MAXI) m_err = 1'b1; else m_infl = ni;
      for (int r = 0; r < 32; r++) d[r] = 0;
      if (fire && bus.dec_rd_we && bus.dec_rd != 0) d[bus.dec_rd]++;
      if (bus.wb_vld && bus.wb_we && bus.wb_rd != 0) begin
        if (m_pend[bus.wb_rd] == 0) m_err = 1'b1;
        d[bus.wb_rd]--;
      end
      for (int r = 1; r < 32; r++) begin
        nv = m_pend[r] + d[r];
        if (nv < 0 || nv > CMAX) m_err = 1'b1; else m_pend[r] = nv;
      end
    end
    @(posedge clk);
    #1;
    chk("inflight", 32'(bus.inflight), 32'(m_infl));
    chk("sb_busy", 32'(bus.sb_busy), 32'(model_busy()));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    chk("sb_err", 32'(bus.sb_err), 32'(m_err));
    @(negedge clk);
  endtask

  task automatic idle();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    set_fire(0, 0);
    bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
    m_infl = 0; m_stall = 0; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_inflight", 32'(bus.inflight), 32'd0);
    chk("rst_busy", 32'(bus.sb_busy), 32'd0);
    chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
    chk("rst_err", 32'(bus.sb_err), 32'd0);
  endtask

  initial begin
    bit ok;
    int pick;
    idle();
    @(negedge clk);
    do_reset();

    // Reset then idle issue.
    set_dec(1, 5'd3, 1, 0, 0, 5'd5, 1);
    step(1);
    // RAW: fire rd=5, then reader of x5 stalls.
    set_fire(1, 1);
    step(1);
    set_fire(0, 0);
    set_dec(1, 5'd5, 1, 0, 0, 5'd6, 1);
    step(0);
    chk("raw_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    set_wb(1, 1, 5'd5);
    step(BYP ? 1 : 0);
    set_wb(0, 0, 0);
    step(1);
    chk("raw_cleared_inflight", 32'(bus.inflight), 32'd0);

    // x0 destinations and in-flight depth.
    set_dec(1, 0, 0, 0, 0, 5'd0, 1);
    set_fire(1, 1);
    repeat (4) step(1);
    chk("x0_busy", 32'(bus.sb_busy), 32'd0);
    chk("depth_inflight", 32'(bus.inflight), 32'd4);
    set_fire(0, 0);
    step(0);
    set_wb(1, 0, 0);
    set_fire(1, 1);
    step(1);
    chk("full_retire_inflight", 32'(bus.inflight), 32'd4);
    set_fire(0, 0);
    repeat (4) step(-1);

    // WAW saturation on x7.
    set_wb(0, 0, 0);
    set_dec(1, 0, 0, 0, 0, 5'd7, 1);
    set_fire(1, 1);
    repeat (3) step(1);
    set_fire(0, 0);
    step(0);
    set_wb(1, 1, 5'd7);
    step(0);
    set_wb(0, 0, 0);
    step(1);
    chk("waw_inflight", 32'(bus.inflight), 32'd2);
    bus.flush = 1'b1;
    step(0);
    bus.flush = 1'b0;

    // Flush with simultaneous fire and retire.
    set_dec(1, 0, 0, 0, 0, 5'd9, 1);
    set_fire(1, 1);
    repeat (2) step(1);
    set_dec(1, 0, 0, 0, 0, 5'd0, 0);
    step(1);
    chk("preflush_inflight", 32'(bus.inflight), 32'd3);
    set_dec(1, 0, 0, 0, 0, 5'd9, 1);
    set_wb(1, 1, 5'd9);
    bus.flush = 1'b1;
    step(0);
    chk("flush_inflight", 32'(bus.inflight), 32'd0);
    chk("flush_busy", 32'(bus.sb_busy), 32'd0);
    chk("flush_err", 32'(bus.sb_err), 32'd0);
    idle();

    // Randomised legal traffic on a small register window.
    for (int n = 0; n < 800; n++) begin
      set_dec($urandom_range(99) < 85, 5'($urandom_range(7)), 1'($urandom),
              5'($urandom_range(7)), 1'($urandom), 5'($urandom_range(7)), 1'($urandom));
      set_wb(0, 0, 0);
      if (m_infl > 0 && $urandom_range(99) < 40) begin
        pick = 0;
        for (int r = 1; r < 8; r++) if (m_pend[r] > 0 && (pick == 0 || $urandom_range(1) == 1)) pick = r;
        if (pick != 0 && $urandom_range(3) != 0) set_wb(1, 1, 5'(pick));
        else set_wb(1, 0, 5'($urandom_range(7)));
      end
      bus.flush = ($urandom_range(99) < 4);
      #1;
      ok = model_ok();
      set_fire(ok && ($urandom_range(3) != 0), $urandom_range(3) != 0);
      step(-1);
    end
    idle();
    bus.flush = 1'b1;
    step(0);
    idle();

    // Retire with nothing in flight: sticky error.
    set_wb(1, 0, 0);
    step(-1);
    chk("err_set", 32'(bus.sb_err), 32'd1);
    set_wb(0, 0, 0);
    repeat (3) step(-1);
    chk("err_sticky", 32'(bus.sb_err), 32'd1);

    // Stall counter saturation: hold a RAW stall on x10.
    set_dec(1, 0, 0, 0, 0, 5'd10, 1);
    set_fire(1, 1);
    step(1);
    set_fire(0, 0);
    set_dec(1, 5'd10, 1, 0, 0, 5'd11, 1);
    while (m_stall < 16'hFFFE) step(0);
    chk("stall_fffe", 32'(bus.stall_cnt), 32'hFFFE);
    repeat (3) step(0);
    chk("stall_sat", 32'(bus.stall_cnt), 32'hFFFF);

    idle();
    @(negedge clk);
    do_reset();
    chk("final_err_cleared", 32'(bus.sb_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/riscv_ex_sched.md
Name: riscv_ex_sched

Overview:
- Issue scheduler and scoreboard between the ID and EX stages.
- Tracks destination registers of in-flight instructions (issued into EX, not yet written back) and bounds total in-flight depth.
- Drives a combinational issue_ok; ID gates id_ex_rdy with it, which blocks RAW and saturated-WAW hazards without forwarding.
- Also provides flush, a sticky protocol-error flag and a stall performance counter.

Parameters:
- CNT_W, 2, width of per-register pending counter; max pending writes per register = 2^CNT_W-1.
- MAX_INFLIGHT, 4, max instructions between issue and writeback (1..15).
- INF_W, 4, width of inflight counter; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- dec_vld  in  1  ID holds a decoded instruction.
- dec_rs1  in  5  source register 1 index.
- dec_rs1_en  in  1  instruction reads rs1.
- dec_rs2  in  5  source register 2 index.
- dec_rs2_en  in  1  instruction reads rs2.
- dec_rd  in  5  destination index.
- dec_rd_we  in  1  instruction writes rd.
- id_ex_rdy  in  1  ID→EX valid (already gated by issue_ok).
- id_ex_ack  in  1  EX accepts; fire = id_ex_rdy & id_ex_ack.
- wb_vld  in  1  one instruction retires this cycle.
- wb_we  in  1  retiring instruction writes wb_rd.
- wb_rd  in  5  retiring destination.
- flush  in  1  kill all in-flight instructions.
- issue_ok  out  1  combinational: ID may present instruction to EX.
- sb_busy  out  1  registered: any pending counter non-zero.
- inflight  out  INF_W  registered in-flight count.
- stall_cnt  out  16  registered saturating stall counter.
- sb_err  out  1  sticky protocol error.

Behaviour:
- State: cnt[1..31] (CNT_W each; x0 never tracked), inflight, stall_cnt, sb_err.
- Reset (rst=1 at edge): all cnt=0, inflight=0, stall_cnt=0, sb_err=0, sb_busy=0. Reset mid-operation discards all tracking; no pending retire is remembered.
- Hazards (combinational):
  - raw1 = dec_rs1_en & dec_rs1!=0 & cnt[dec_rs1]!=0.
  - raw2 = same for rs2.
  - waw = dec_rd_we & dec_rd!=0 & cnt[dec_rd]==2^CNT_W-1.
  - full = inflight==MAX_INFLIGHT & !wb_vld. Retirement in the same cycle frees a slot.
- issue_ok = dec_vld & !raw1 & !raw2 & !waw & !full & !flush. Zero-latency: it depends on current inputs and registered state only.
- Fire update, next edge:
  - inflight +1.
  - If dec_rd_we & dec_rd!=0: cnt[dec_rd] +1.
- Retire update (wb_vld):
  - inflight −1.
  - If wb_we & wb_rd!=0: cnt[wb_rd] −1.
- Fire and retire together: net deltas sum; same register gives cnt unchanged; inflight unchanged.
- Flush (priority over fire and retire in the same cycle):
  - All cnt=0, inflight=0.
  - Fire and retire that cycle are ignored.
  - Instructions killed by flush must not produce wb_vld afterwards; the caller guarantees this.
- sb_err set (sticky until rst) on any of:
  - fire while issue_ok=0;
  - retire with inflight=0;
  - register retire with cnt[wb_rd]=0;
  - counter overflow.
- Counters never wrap: overflow/underflow leaves the value unchanged and only sets sb_err.
- stall_cnt: +1 each cycle with dec_vld & !issue_ok & !flush; saturates at 0xFFFF; cleared only by rst.
- sb_busy = OR of cnt, registered, i.e. reflects post-edge state.

Optional Feature:
- Macro RISCV_SB_WB_BYPASS_EN.
  - Defined: a RAW hazard on rs is suppressed when wb_vld & wb_we & wb_rd==rs & cnt[rs]==1. The register file writes through, so the instruction issues in the same cycle as the writeback.
  - Undefined: the source stays blocked until the cycle after the counter reaches 0, a one-cycle bubble per dependency.
- WAW saturation and full checks are identical in both builds.

Test Plan:
- Reset then idle: rst 1 cycle → cnt all 0, inflight=0, stall_cnt=0, sb_err=0; dec_vld=1 rd=5 rs1=3 → issue_ok=1.
- RAW stall:
  - fire rd=5; next cycle dec rs1=5 → issue_ok=0, stall_cnt increments.
  - wb_vld wb_we wb_rd=5 → issue_ok=1 the next cycle without the macro, the same cycle with RISCV_SB_WB_BYPASS_EN.
- x0 and depth:
  - four fires rd=0 → cnt unchanged, inflight=4, next dec → issue_ok=0 (full).
  - same cycle wb_vld=1 → issue_ok=1, inflight stays 4.
- WAW saturation (CNT_W=2): three fires rd=7 → cnt[7]=3, fourth dec rd=7 → issue_ok=0; retire rd=7 → cnt[7]=2, issue_ok=1.
- Flush: inflight=3, cnt[9]=2, flush with simultaneous fire and retire → next cycle inflight=0, sb_busy=0, sb_err=0.
- Errors and saturation:
  - retire with inflight=0 → sb_err=1, held until rst.
  - force stall_cnt to 0xFFFE, hold 3 stall cycles → reads 0xFFFF.
